action_value_agent: RTL and testbench

Parametrised epsilon-greedy action-value agent, the successor to the 8-bit bandit table. It holds a Q-table of 2^ACTION_WIDTH signed entries and selects a greedy action by a deterministic full-table argmax sweep. Every EXPLORE_PERIOD actions it instead takes an LFSR-chosen exploratory action. It issues the action on a valid/ready stream, then applies the exponential-average update when the environment returns a reward.

---
 rtl/action_value_agent.sv | 254 +++++++++++++++++++++++++
 tb/tb_action_value_agent.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/action_value_agent.sv
// action_value_agent: epsilon-greedy action-value agent.
// Holds a Q-table of 2^ACTION_WIDTH signed entries. Each decision sweeps the
// whole table for the argmax (ties go to the lowest index). The chosen action
// is issued on a valid/ready stream, and the returned reward then updates the
// entry by exponential averaging with step 2^-ALPHA_SHIFT.
// Optional feature macro: ACTION_VALUE_AGENT_EPSILON_EN enables periodic
// LFSR-driven exploration (one exploratory action every EXPLORE_PERIOD).
module action_value_agent #(
    parameter int ACTION_WIDTH   = 8,
    parameter int VALUE_WIDTH    = 16,
    parameter int REWARD_WIDTH   = 8,
    parameter int ALPHA_SHIFT    = 3,
    parameter int INIT_VALUE     = -128,
    parameter int EXPLORE_PERIOD = 16,
    parameter logic [ACTION_WIDTH-1:0] SEED = '1,
    parameter logic [ACTION_WIDTH-1:0] TAPS = ACTION_WIDTH'(8'hb1)
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    reward_valid,
    input  logic [REWARD_WIDTH-1:0] reward_data,
    output logic                    reward_ready,
    output logic                    action_valid,
    output logic [ACTION_WIDTH-1:0] action_data,
    input  logic                    action_ready,
    output logic                    action_explored,
    input  logic                    greedy_only
);

    localparam int DEPTH = 1 << ACTION_WIDTH;
    localparam int IW    = ACTION_WIDTH + 1;
    localparam logic signed [VALUE_WIDTH-1:0] INIT_V = VALUE_WIDTH'(INIT_VALUE);
    localparam logic signed [VALUE_WIDTH-1:0] VMIN   = {1'b1, {(VALUE_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_INIT,
        ST_DECIDING,
        ST_ACTUATING,
        ST_OBSERVING
    } state_t;

    state_t state_q, state_d;
    logic [IW-1:0]                  idx_q, idx_d;
    logic signed [VALUE_WIDTH-1:0]  best_q, best_d;
    logic [ACTION_WIDTH-1:0]        best_idx_q, best_idx_d;
    logic [ACTION_WIDTH-1:0]        actuation_q, actuation_d;
    logic signed [VALUE_WIDTH-1:0]  utility_q, utility_d;

    logic signed [VALUE_WIDTH-1:0]  q_mem [DEPTH];
    logic signed [VALUE_WIDTH-1:0]  rd_data_q;
    logic                           mem_we;
    logic [ACTION_WIDTH-1:0]        mem_waddr;
    logic signed [VALUE_WIDTH-1:0]  mem_wdata;

    logic                           sweep_first;
    logic                           sweep_done;
    logic [ACTION_WIDTH-1:0]        last_idx;
    logic                           cmp_gt;
    logic signed [VALUE_WIDTH-1:0]  fin_best;
    logic [ACTION_WIDTH-1:0]        fin_idx;

    logic                           explore_sel;
    logic [ACTION_WIDTH-1:0]        target_sel;
    logic signed [VALUE_WIDTH-1:0]  target_val;

    logic signed [VALUE_WIDTH:0]    reward_ext;
    logic signed [VALUE_WIDTH:0]    util_ext;
    logic signed [VALUE_WIDTH:0]    diff;
    logic signed [VALUE_WIDTH:0]    step;
    logic signed [VALUE_WIDTH:0]    sum;
    logic signed [VALUE_WIDTH-1:0]  q_new;

    assign action_valid = (state_q == ST_ACTUATING);
    assign reward_ready = (state_q == ST_OBSERVING);
    assign action_data  = actuation_q;

    // Sweep bookkeeping: rd_data_q holds the entry read one cycle earlier,
    // so its index is idx_q-1 (wrapping to DEPTH-1 on the final cycle).
    always_comb begin
        sweep_first = (idx_q == '0);
        sweep_done  = (idx_q == IW'(DEPTH));
        last_idx    = idx_q[ACTION_WIDTH-1:0] - ACTION_WIDTH'(1);
        cmp_gt      = (rd_data_q > best_q);
        fin_best    = cmp_gt ? rd_data_q : best_q;
        fin_idx     = cmp_gt ? last_idx : best_idx_q;
    end

    // Exponential-average update; the result lies between Q and R, so
    // truncation back to VALUE_WIDTH cannot overflow.
    always_comb begin
        reward_ext = {{(VALUE_WIDTH+1-REWARD_WIDTH){reward_data[REWARD_WIDTH-1]}}, reward_data};
        util_ext   = {utility_q[VALUE_WIDTH-1], utility_q};
        diff       = reward_ext - util_ext;
        step       = diff >>> ALPHA_SHIFT;
        sum        = util_ext + step;
        q_new      = sum[VALUE_WIDTH-1:0];
    end

    // Main FSM next-state, sweep datapath and table write port.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        best_d      = best_q;
        best_idx_d  = best_idx_q;
        actuation_d = actuation_q;
        utility_d   = utility_q;
        mem_we      = 1'b0;
        mem_waddr   = idx_q[ACTION_WIDTH-1:0];
        mem_wdata   = INIT_V;
        case (state_q)
            ST_INIT: begin
                mem_we = 1'b1;
                if (idx_q == IW'(DEPTH-1)) begin
                    idx_d   = '0;
                    state_d = ST_DECIDING;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            ST_DECIDING: begin
                if (sweep_first) begin
                    best_d     = VMIN;
                    best_idx_d = '0;
                end else begin
                    best_d     = fin_best;
                    best_idx_d = fin_idx;
                end
                if (sweep_done) begin
                    idx_d   = '0;
                    state_d = ST_ACTUATING;
                    if (explore_sel) begin
                        actuation_d = target_sel;
                        utility_d   = target_val;
                    end else begin
                        actuation_d = fin_idx;
                        utility_d   = fin_best;
                    end
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            ST_ACTUATING: begin
                if (action_ready) begin
                    state_d = ST_OBSERVING;
                end
            end
            ST_OBSERVING: begin
                if (reward_valid) begin
                    mem_we    = 1'b1;
                    mem_waddr = actuation_q;
                    mem_wdata = q_new;
                    state_d   = ST_DECIDING;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Main FSM and datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_INIT;
            idx_q       <= '0;
            best_q      <= '0;
            best_idx_q  <= '0;
            actuation_q <= '0;
            utility_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            best_q      <= best_d;
            best_idx_q  <= best_idx_d;
            actuation_q <= actuation_d;
            utility_q   <= utility_d;
        end
    end

    // Q-table: one write port, one synchronous read port addressed by the sweep index.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            q_mem[mem_waddr] <= mem_wdata;
        end
        rd_data_q <= q_mem[idx_q[ACTION_WIDTH-1:0]];
    end

`ifdef ACTION_VALUE_AGENT_EPSILON_EN
    localparam int CW = $clog2(EXPLORE_PERIOD);

    logic [CW-1:0]                  count_q, count_d;
    logic [ACTION_WIDTH-1:0]        lfsr_q, lfsr_d;
    logic                           explore_q, explore_d;
    logic [ACTION_WIDTH-1:0]        target_q, target_d;
    logic signed [VALUE_WIDTH-1:0]  captured_q, captured_d;
    logic                           explored_q, explored_d;

    assign explore_sel     = explore_q;
    assign target_sel      = target_q;
    // The target may be the entry arriving on the final sweep cycle.
    assign target_val      = (last_idx == target_q) ? rd_data_q : captured_q;
    assign action_explored = explored_q;

    // Exploration control: action counter, free-running LFSR, target capture.
    always_comb begin
        count_d    = count_q;
        lfsr_d     = {lfsr_q[ACTION_WIDTH-2:0], ^(lfsr_q & TAPS)};
        explore_d  = explore_q;
        target_d   = target_q;
        captured_d = captured_q;
        explored_d = explored_q;
        if (state_q == ST_DECIDING) begin
            if (sweep_first) begin
                explore_d = ~greedy_only & (count_q == CW'(EXPLORE_PERIOD-1));
                target_d  = lfsr_q;
            end else if (last_idx == target_q) begin
                captured_d = rd_data_q;
            end
            if (sweep_done) begin
                explored_d = explore_q;
            end
        end
        if ((state_q == ST_ACTUATING) && action_ready) begin
            count_d = (count_q == CW'(EXPLORE_PERIOD-1)) ? '0 : count_q + CW'(1);
        end
    end

    // Exploration registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q    <= '0;
            lfsr_q     <= SEED;
            explore_q  <= 1'b0;
            target_q   <= '0;
            captured_q <= '0;
            explored_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            lfsr_q     <= lfsr_d;
            explore_q  <= explore_d;
            target_q   <= target_d;
            captured_q <= captured_d;
            explored_q <= explored_d;
        end
    end
`else
    logic unused_eps;

    assign explore_sel     = 1'b0;
    assign target_sel      = '0;
    assign target_val      = '0;
    assign action_explored = 1'b0;
    assign unused_eps      = greedy_only ^ (^SEED) ^ (^TAPS) ^ EXPLORE_PERIOD[0];
`endif

endmodule

// File: tb/tb_action_value_agent.sv
// Directed bench for action_value_agent (ACTION_WIDTH=3, EXPLORE_PERIOD=4).
// Expected actions come from a small table model with hand-checked update
// arithmetic and an LFSR model indexed by edges since reset release.
module tb_action_value_agent;

    localparam int AW = 3;
    localparam int P  = 4;
`ifdef ACTION_VALUE_AGENT_EPSILON_EN
    localparam bit EPS = 1'b1;
`else
    localparam bit EPS = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          reward_valid = 1'b0;
    logic [7:0]    reward_data = '0;
    logic          reward_ready;
    logic          action_valid;
    logic [AW-1:0] action_data;
    logic          action_ready = 1'b0;
    logic          action_explored;
    logic          greedy_only = 1'b0;

    action_value_agent #(
        .ACTION_WIDTH   (AW),
        .VALUE_WIDTH    (16),
        .REWARD_WIDTH   (8),
        .ALPHA_SHIFT    (3),
        .INIT_VALUE     (-128),
        .EXPLORE_PERIOD (P),
        .SEED           (3'b111),
        .TAPS           (3'b110)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .reward_valid    (reward_valid),
        .reward_data     (reward_data),
        .reward_ready    (reward_ready),
        .action_valid    (action_valid),
        .action_data     (action_data),
        .action_ready    (action_ready),
        .action_explored (action_explored),
        .greedy_only     (greedy_only)
    );

    always #5 clock = ~clock;

    int edge_cnt;
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) edge_cnt <= 0;
        else          edge_cnt <= edge_cnt + 1;
    end

    int checks   = 0;
    int failures = 0;
    int qm [8];
    int count_m;
    int exp_edge;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int lfsr_after(input int n);
        logic [2:0] s;
        s = 3'b111;
        for (int i = 0; i < n; i++) s = {s[1:0], ^(s & 3'b110)};
        return int'(s);
    endfunction

    function automatic int argmax_m();
        int b;
        b = 0;
        for (int i = 1; i < 8; i++) if (qm[i] > qm[b]) b = i;
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) qm[i] = -128;
        count_m  = 0;
        exp_edge = 17;
    endtask

    task automatic wait_valid(output bit ok);
        int waited;
        waited = 0;
        while (!action_valid && waited < 40) begin
            @(negedge clock);
            waited++;
        end
        ok = action_valid;
        if (!ok) check_eq("valid_timeout", 0, 1);
    endtask

    // One full decision/actuation/reward round, called on a falling edge.
    task automatic do_action(input int rew, input bit hold, output int act);
        bit ok;
        int e, exp_act;
        bit exp_expl;
        act = 0;
        wait_valid(ok);
        if (!ok) return;
        e = edge_cnt;
        check_eq("latency", e, exp_edge);
        exp_expl = EPS && !greedy_only && (count_m == P-1);
        exp_act  = exp_expl ? lfsr_after(e - 9) : argmax_m();
        check_eq("action_data", int'(action_data), exp_act);
        check_eq("action_explored", int'(action_explored), int'(exp_expl));
        check_eq("reward_ready_in_act", int'(reward_ready), 0);
        if (hold) begin
            reward_valid = 1'b1;
            reward_data  = 8'sd99;
            repeat (5) begin
                @(negedge clock);
                check_eq("hold_valid", int'(action_valid), 1);
                check_eq("hold_data", int'(action_data), exp_act);
                check_eq("hold_explored", int'(action_explored), int'(exp_expl));
                check_eq("hold_reward_ready", int'(reward_ready), 0);
            end
            reward_valid = 1'b0;
        end
        action_ready = 1'b1;
        @(negedge clock);
        action_ready = 1'b0;
        count_m = (count_m + 1) % P;
        check_eq("obs_reward_ready", int'(reward_ready), 1);
        check_eq("obs_valid", int'(action_valid), 0);
        reward_valid = 1'b1;
        reward_data  = 8'(rew);
        @(negedge clock);
        reward_valid = 1'b0;
        check_eq("post_reward_ready", int'(reward_ready), 0);
        qm[exp_act] = qm[exp_act] + ((rew - qm[exp_act]) >>> 3);
        exp_edge = edge_cnt + 9;
        act = exp_act;
    endtask

    int greedy_rew [12] = '{-128, -128, -128, -128, -128, -128, -128, -128, 20, -50, 0, 127};
    int tail_rew   [4]  = '{-128, -128, -128, 120};

    initial begin
        int a;
        bit ok;
        model_reset();
        repeat (3) @(negedge clock);
        check_eq("reset_valid", int'(action_valid), 0);
        check_eq("reset_data", int'(action_data), 0);
        check_eq("reset_explored", int'(action_explored), 0);
        check_eq("reset_reward_ready", int'(reward_ready), 0);
        reset_n = 1'b1;

        // Q[0]: -128 -> -97 -> -101 -> -76; the fourth decision explores.
        do_action(127, 1'b0, a);
        check_eq("q0_after_127", qm[0], -97);
        do_action(-128, 1'b0, a);
        check_eq("q0_after_m128", qm[0], -101);
        do_action(100, 1'b0, a);
        do_action(50, 1'b1, a);

        greedy_only = 1'b1;
        foreach (greedy_rew[i]) do_action(greedy_rew[i], 1'b0, a);
        greedy_only = 1'b0;
        foreach (tail_rew[i]) do_action(tail_rew[i], 1'b0, a);

        // Reset in OBSERVING discards the round and reinitialises the table.
        wait_valid(ok);
        if (ok) begin
            action_ready = 1'b1;
            @(negedge clock);
            action_ready = 1'b0;
            check_eq("pre_reset_reward_ready", int'(reward_ready), 1);
            reset_n = 1'b0;
            #1;
            check_eq("rst_valid", int'(action_valid), 0);
            check_eq("rst_data", int'(action_data), 0);
            check_eq("rst_explored", int'(action_explored), 0);
            check_eq("rst_reward_ready", int'(reward_ready), 0);
            @(negedge clock);
            reset_n = 1'b1;
            model_reset();
            do_action(10, 1'b0, a);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
